// File: rtl/mem_pkg.sv
// Shared memory-side types: arbiter FSM states and port owners.
// Reused by the arbiter and the cache/bus blocks that follow it.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-port memory, one transaction
// in flight; data wins unless fetch has waited MAX_D_STREAK grants.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_done_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_if_o,
  output logic                stall_mem_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  arb_state_t state;
  arb_state_t state_n;
  owner_t     owner;
  logic [3:0] d_streak;
  logic       grant_d;
  logic       grant_if;
  logic       d_prio;

  // Fetch only overtakes a waiting data request once the streak is full.
  assign d_prio = ~if_req_i | (d_streak != MAX_S);

  always_comb begin
    state_n  = state;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    unique case (state)
      IDLE: begin
        grant_d  = d_req_i & d_prio;
        grant_if = if_req_i & ~grant_d;
        if (grant_d | grant_if)
          state_n = REQ;
      end
      REQ: begin
        if (mem_ready_i)
          state_n = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i)
          state_n = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      d_streak    <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      state <= state_n;
      if (grant_d) begin
        owner       <= OWN_D;
        mem_we_o    <= d_we_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        mem_be_o    <= d_be_i;
        if (!if_req_i)
          d_streak <= '0;
        else if (d_streak != MAX_S)
          d_streak <= d_streak + 4'd1;
      end
      if (grant_if) begin
        owner       <= OWN_IF;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
        mem_be_o    <= {BE_W{1'b1}};
        d_streak    <= '0;
      end
      if (state == WAIT && mem_rvalid_i) begin
        if (owner == OWN_IF)
          if_rdata_o <= mem_rdata_i;
        else
          d_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign mem_valid_o = (state == REQ);
  assign if_done_o   = (state == RESP) & (owner == OWN_IF);
  assign d_done_o    = (state == RESP) & (owner == OWN_D);
  assign stall_if_o  = if_req_i & ~if_done_o;
  assign stall_mem_o = d_req_i & ~d_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, starvation,
// backpressure, reset abandon and stray responses.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_done_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_done_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o),
    .d_req_i(d_req_i),
    .d_we_i(d_we_i),
    .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i),
    .d_rdata_o(d_rdata_o),
    .d_done_o(d_done_o),
    .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o),
    .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq_addr [6];
    seq_addr = '{32'h200, 32'h200, 32'h200,
                 32'h200, 32'h80, 32'h200};

    rst_n        = 1'b0;
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    d_req_i      = 1'b0;
    d_we_i       = 1'b0;
    d_addr_i     = '0;
    d_wdata_i    = '0;
    d_be_i       = '0;
    mem_ready_i  = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_valid", 32'(mem_valid_o), 0);
    check("rst_done", {if_done_o, d_done_o}, 0);
    check("rst_rdata", if_rdata_o | d_rdata_o, 0);
    check("rst_addr", mem_addr_o, 0);

    // fetch alone
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    #1;
    check("f_stall", 32'(stall_if_o), 1);
    step();
    check("f_valid", 32'(mem_valid_o), 1);
    check("f_addr", mem_addr_o, 32'h40);
    check("f_be_we", {mem_be_o, mem_we_o}, 5'b11110);
    step();
    check("f_wait_valid", 32'(mem_valid_o), 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0051_3023;
    step();
    mem_rvalid_i = 1'b0;
    check("f_done", 32'(if_done_o), 1);
    check("f_rdata", if_rdata_o, 32'h0051_3023);
    check("f_stall_done", 32'(stall_if_o), 0);
    if_req_i = 1'b0;
    step();
    check("f_done_off", 32'(if_done_o), 0);
    check("f_rdata_hold", if_rdata_o, 32'h0051_3023);

    // simultaneous store and fetch
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h100;
    d_wdata_i = 32'hDEAD_BEEF;
    d_be_i    = 4'b0011;
    if_req_i  = 1'b1;
    if_addr_i = 32'h44;
    step();
    check("s_addr", mem_addr_o, 32'h100);
    check("s_we_be", {mem_we_o, mem_be_o}, 5'b10011);
    check("s_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_2222;
    step();
    mem_rvalid_i = 1'b0;
    check("s_done", {d_done_o, if_done_o}, 2'b10);
    check("s_stalls", {stall_mem_o, stall_if_o}, 2'b01);
    check("s_drdata", d_rdata_o, 32'h1111_2222);
    d_req_i = 1'b0;
    d_we_i  = 1'b0;
    step();
    check("s_idle", 32'(dut.state), 32'(IDLE));
    step();
    check("s_f_addr", mem_addr_o, 32'h44);
    check("s_f_payload", {mem_we_o, mem_be_o}, 5'b01111);
    check("s_f_wdata", mem_wdata_o, 0);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h33;
    step();
    mem_rvalid_i = 1'b0;
    check("s_f_done", 32'(if_done_o), 1);
    check("s_f_rdata", if_rdata_o, 32'h33);
    if_req_i = 1'b0;
    step();

    // starvation: both held, 4 data then 1 fetch then data
    d_req_i   = 1'b1;
    d_addr_i  = 32'h200;
    d_be_i    = 4'hF;
    if_req_i  = 1'b1;
    if_addr_i = 32'h80;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++)
        if (!mem_valid_o) step();
      check($sformatf("v_grant%0d", t),
            32'(mem_valid_o), 1);
      check($sformatf("v_addr%0d", t),
            mem_addr_o, seq_addr[t]);
      step();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1000 + 32'(t);
      step();
      mem_rvalid_i = 1'b0;
      step();
    end
    d_req_i  = 1'b0;
    if_req_i = 1'b0;
    check("v_if_rdata", if_rdata_o, 32'h1004);
    check("v_d_rdata", d_rdata_o, 32'h1005);

    // backpressure
    d_addr_i = 32'h300;
    d_req_i  = 1'b1;
    mem_ready_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("b_valid%0d", c),
            32'(mem_valid_o), 1);
      check($sformatf("b_addr%0d", c),
            mem_addr_o, 32'h300);
      step();
    end
    d_req_i     = 1'b0;
    mem_ready_i = 1'b1;
    step();
    check("b_wait", 32'(dut.state), 32'(WAIT));
    check("b_wait_valid", 32'(mem_valid_o), 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77;
    step();
    mem_rvalid_i = 1'b0;
    check("b_done", 32'(d_done_o), 1);
    check("b_rdata", d_rdata_o, 32'h77);
    step();

    // reset during WAIT
    d_req_i  = 1'b1;
    if_req_i = 1'b1;
    step();
    d_req_i  = 1'b0;
    if_req_i = 1'b0;
    step();
    check("r_wait", 32'(dut.state), 32'(WAIT));
    check("r_streak1", 32'(dut.d_streak), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("r_idle", 32'(dut.state), 32'(IDLE));
    check("r_valid", 32'(mem_valid_o), 0);
    check("r_streak0", 32'(dut.d_streak), 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD;
    step();
    mem_rvalid_i = 1'b0;
    check("r_no_done", {if_done_o, d_done_o}, 0);
    check("r_rdata", d_rdata_o, 0);
    step();
    check("r_no_done2", {if_done_o, d_done_o}, 0);

    // stray responses in IDLE and REQ
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555;
    step();
    check("x_idle_done", {if_done_o, d_done_o}, 0);
    check("x_idle_rdata", if_rdata_o | d_rdata_o, 0);
    mem_ready_i = 1'b0;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h90;
    step();
    check("x_req", 32'(dut.state), 32'(REQ));
    step();
    mem_rvalid_i = 1'b0;
    check("x_req_done", {if_done_o, d_done_o}, 0);
    check("x_req_rdata", if_rdata_o, 0);
    mem_ready_i = 1'b1;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h9999;
    step();
    mem_rvalid_i = 1'b0;
    if_req_i     = 1'b0;
    check("x_done", 32'(if_done_o), 1);
    check("x_rdata", if_rdata_o, 32'h9999);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester of the RV32I pipeline.
- Runs a grant FSM with one outstanding transaction, registers the winning request onto a valid/ready memory port, and returns the response to its owner.
- Drives stall requests to the hazard unit while a requester is waiting.
- Data accesses win by default; a streak counter prevents fetch starvation.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch waits; legal range 1..15.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- if_req_i  in  1  fetch request; held high until if_done_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched word; valid when if_done_o.
- if_done_o  out  1  one-cycle fetch completion pulse.
- d_req_i  in  1  data request; held high until d_done_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_be_i  in  DATA_W/8  byte enables.
- d_rdata_o  out  DATA_W  load data; valid when d_done_o.
- d_done_o  out  1  one-cycle data completion pulse.
- mem_valid_o  out  1  memory request valid.
- mem_ready_i  in  1  memory accepts the request.
- mem_we_o  out  1  write.
- mem_addr_o  out  ADDR_W  address.
- mem_wdata_o  out  DATA_W  write data.
- mem_be_o  out  DATA_W/8  byte enables.
- mem_rvalid_i  in  1  response or write acknowledge.
- mem_rdata_i  in  DATA_W  response data.
- stall_if_o  out  1  = if_req_i & ~if_done_o (combinational).
- stall_mem_o  out  1  = d_req_i & ~d_done_o (combinational).

## Operation
States and transitions:
- IDLE: arbitrate on the current request inputs.
  - Only one request high: grant it.
  - Both high: grant data unless d_streak == MAX_D_STREAK, in which case grant fetch.
  - On grant, latch owner and payload; the fetch payload is we=0, be=all ones, wdata=0. Go to REQ.
- REQ: mem_valid_o=1 with the latched payload stable. Go to WAIT on mem_ready_i.
- WAIT: mem_valid_o=0. On mem_rvalid_i, capture mem_rdata_i into the owner's rdata register and go to RESP.
- RESP: pulse the owner's done for exactly one cycle, then go to IDLE.

Rules:
- One transaction outstanding, never more.
- mem_rvalid_i outside WAIT is ignored.
- Stores also wait for mem_rvalid_i; d_rdata_o then holds whatever mem_rdata_i carried.
- d_streak is a 4-bit counter:
  - increments on a data grant while if_req_i=1, saturating at MAX_D_STREAK;
  - clears on a fetch grant, or on a data grant with if_req_i=0.
- Requests are sampled only in IDLE. A requester that drops its request mid-transaction still has the transaction completed and done pulsed.
- A requester may keep its request high in its done cycle to start a new transaction; it is arbitrated in the following IDLE cycle.
- if_rdata_o and d_rdata_o hold their last captured value between transactions.

Reset (rst_n=0 at a rising edge):
- State goes to IDLE and owner to fetch.
- d_streak, both rdata registers and all mem_* payload registers clear to 0.
- mem_valid_o, if_done_o and d_done_o are 0.
- A reset mid-transaction abandons it; a later stray mem_rvalid_i is ignored.

## Timing
- Request at edge N in IDLE gives mem_valid_o high from N+1.
- Accepted (mem_ready_i=1) at edge A gives WAIT from A+1.
- mem_rvalid_i at edge R gives done and rdata at R+1 (RESP), and IDLE at R+2.
- Minimum request-to-done latency is 3 cycles (ready in the first REQ cycle, rvalid in the first WAIT cycle).
- Back-to-back service costs 4 cycles per transaction.
- mem_ready_i low holds REQ indefinitely with the payload unchanged.

## Structure
- State enum arb_state_t {IDLE, REQ, WAIT, RESP} and owner enum owner_t {OWN_IF, OWN_D} go in a shared mem_pkg, reused by the future cache/bus blocks.
- No sub-module; a single always_ff for state, owner, payload and streak, plus an always_comb for next-state and grant.

## Test plan
- Fetch alone: if_req_i=1, if_addr_i=0x0000_0040, memory ready=1, rvalid next cycle with 0x0051_3023. Required: mem_valid_o at N+1, if_done_o at N+3, if_rdata_o=0x0051_3023, stall_if_o low only in the done cycle.
- Simultaneous requests: store d_addr_i=0x100, d_wdata_i=0xDEAD_BEEF, d_be_i=4'b0011, plus a fetch. Required: data granted first with mem_be_o=0011 and mem_we_o=1; fetch granted in the IDLE following d_done_o.
- Starvation: d_req_i held high continuously with if_req_i high and MAX_D_STREAK=4. Required: exactly 4 data grants, then 1 fetch grant, then data resumes.
- Backpressure: mem_ready_i low for 5 cycles. Required: mem_valid_o and payload stable for all 5 cycles; WAIT entered the cycle after ready rises.
- Reset mid-operation: rst_n low for 1 cycle during WAIT, then mem_rvalid_i pulses. Required: no done pulse, mem_valid_o=0, state IDLE, d_streak=0.
- Stray response: mem_rvalid_i pulsed in IDLE and REQ. Required: no done pulse and rdata registers unchanged.
